// File: rtl/iir_biquad_cascade.sv
// Cascade of N_SECT Direct-Form-I biquad sections sharing one multiply-accumulate unit.
// Each sample runs 5 MAC cycles and 1 write-back cycle per section. The block has
// runtime-programmable coefficients, a bypass path and a history flush.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge where
// valid & ready are both 1. A producer that raises valid holds it, and holds its data
// stable, until that transfer. Here in_ready is high only in IDLE, and it is held low
// during a flush cycle. out_valid/out_data are held in OUT until out_ready is high.
module iir_biquad_cascade #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 18,
  parameter int FRAC   = 14,
  parameter int N_SECT = 2,
  parameter int ACC_W  = 40,
  localparam int NCOEF = 5 * N_SECT,
  localparam int AW    = $clog2(NCOEF)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              bypass,
  input  logic              flush,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [COEF_W-1:0] coef_wdata,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int SW = (N_SECT > 1) ? $clog2(N_SECT) : 1;
  localparam int PW = DATA_W + COEF_W;

  localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1) << FRAC;
  localparam logic signed [ACC_W-1:0]  ROUND    = ACC_W'(1) << (FRAC - 1);
  localparam logic signed [ACC_W-1:0]  SAT_MAX  = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  SAT_MIN  = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [SW-1:0]            LAST_SECT = SW'(N_SECT - 1);
  localparam logic [AW-1:0]            TAPS      = AW'(5);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_WB   = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t                    state;
  logic [SW-1:0]             sect;
  logic [2:0]                tap;
  logic signed [ACC_W-1:0]   acc;
  logic signed [DATA_W-1:0]  cur_x;
  logic                      rdy_q;

  // Coefficient store, laid out as sect*5 + {b0, b1, b2, a1, a2}
  logic signed [COEF_W-1:0]  coef [NCOEF];

  // Per-section histories
  logic signed [DATA_W-1:0]  x1 [N_SECT];
  logic signed [DATA_W-1:0]  x2 [N_SECT];
  logic signed [DATA_W-1:0]  y1 [N_SECT];
  logic signed [DATA_W-1:0]  y2 [N_SECT];

  logic [AW-1:0]             coef_sel;
  logic signed [DATA_W-1:0]  x_op;
  logic signed [COEF_W-1:0]  c_op;
  logic signed [PW-1:0]      prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   acc_rnd;
  logic signed [ACC_W-1:0]   acc_sh;
  logic signed [DATA_W-1:0]  y_sat;

  // A flush cycle blocks acceptance so the cleared history is never mixed with a new sample
  assign in_ready  = rdy_q & ~flush;
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  // Select the data/coefficient pair for the current tap of the current section
  always_comb begin
    coef_sel = AW'(sect) * TAPS + AW'(tap);
    c_op     = coef[coef_sel];
    x_op     = cur_x;
    case (tap)
      3'd1:    x_op = x1[sect];
      3'd2:    x_op = x2[sect];
      3'd3:    x_op = y1[sect];
      3'd4:    x_op = y2[sect];
      default: x_op = cur_x;
    endcase
  end

  assign prod     = x_op * c_op;
  assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};

  // Round half-up at the coefficient binary point, then clamp to the sample range
  always_comb begin
    acc_rnd = acc + ROUND;
    acc_sh  = acc_rnd >>> FRAC;
    if (acc_sh > SAT_MAX)      y_sat = DATA_MAX;
    else if (acc_sh < SAT_MIN) y_sat = DATA_MIN;
    else                       y_sat = acc_sh[DATA_W-1:0];
  end

  // Sequencer: accept, MAC taps, write back each section, then present the result
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      sect      <= '0;
      tap       <= '0;
      acc       <= '0;
      cur_x     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      rdy_q     <= 1'b0;
      for (int i = 0; i < NCOEF; i++) begin
        coef[i] <= ((i % 5) == 0) ? COEF_ONE : '0;
      end
      for (int s = 0; s < N_SECT; s++) begin
        x1[s] <= '0;
        x2[s] <= '0;
        y1[s] <= '0;
        y2[s] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          rdy_q <= 1'b1;
          // Writes land in the same edge as an accept, so that sample sees the new value
          if (coef_we && (int'(coef_addr) < NCOEF)) begin
            coef[coef_addr] <= coef_wdata;
          end
          if (flush) begin
            for (int s = 0; s < N_SECT; s++) begin
              x1[s] <= '0;
              x2[s] <= '0;
              y1[s] <= '0;
              y2[s] <= '0;
            end
          end else if (in_valid && rdy_q) begin
            rdy_q <= 1'b0;
            if (bypass) begin
              out_data  <= in_data;
              out_valid <= 1'b1;
              state     <= S_OUT;
            end else begin
              cur_x <= in_data;
              sect  <= '0;
              tap   <= '0;
              state <= S_MAC;
            end
          end
        end

        S_MAC: begin
          case (tap)
            3'd0:       acc <= prod_ext;
            3'd1, 3'd2: acc <= acc + prod_ext;
            default:    acc <= acc - prod_ext;
          endcase
          if (tap == 3'd4) begin
            state <= S_WB;
          end else begin
            tap <= tap + 3'd1;
          end
        end

        S_WB: begin
          x2[sect] <= x1[sect];
          x1[sect] <= cur_x;
          y2[sect] <= y1[sect];
          y1[sect] <= y_sat;
          if (sect == LAST_SECT) begin
            out_data  <= y_sat;
            out_valid <= 1'b1;
            state     <= S_OUT;
          end else begin
            sect  <= sect + SW'(1);
            cur_x <= y_sat;
            tap   <= '0;
            state <= S_MAC;
          end
        end

        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            rdy_q     <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          rdy_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule
